// File: rtl/graphics_compositor_pkg.sv
// Shared display definitions for the compositor: default color width,
// test-pattern geometry, flash FSM state type and the bar color lookup.
package DisplayPkg;

    localparam int COLOR_W_DEF  = 24;
    localparam int TP_BAR_W     = 80;
    localparam int TP_SPLIT_ROW = 240;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } flash_state_t;

    // Returns {R,G,B} channel on/off bits of the color-bar test pattern.
    function automatic logic [2:0] tp_rgb(input logic [9:0] row, input logic [9:0] col);
        logic [2:0] rgb;
        logic [9:0] bar;
        rgb = 3'b000;
        bar = col / 10'(TP_BAR_W);
        if (row < 10'(TP_SPLIT_ROW)) begin
            case (bar)
                10'd0:   rgb = 3'b111; // white
                10'd1:   rgb = 3'b110; // yellow
                10'd2:   rgb = 3'b011; // cyan
                10'd3:   rgb = 3'b010; // green
                10'd4:   rgb = 3'b101; // magenta
                10'd5:   rgb = 3'b100; // red
                10'd6:   rgb = 3'b001; // blue
                default: rgb = 3'b000; // black
            endcase
        end
        return rgb;
    endfunction

endpackage

// File: rtl/graphics_compositor_priority_select.sv
// Combinational highest-set-bit encoder: the highest-index requesting
// layer wins, so priority is strict and ties cannot occur.
module priority_select #(
    parameter int  NUM_LAYERS = 12,
    localparam int IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic [NUM_LAYERS-1:0] i_req,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_hit
);

    // Ascending scan; later (higher) indices overwrite earlier ones.
    always_comb begin
        o_idx = '0;
        o_hit = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/graphics_compositor.sv
// Two-stage pixel compositor: frame-synchronous layer enables, priority
// selection, multi-frame flash of one layer and a color-bar test pattern.
module graphics_compositor
    import DisplayPkg::*;
#(
    parameter int NUM_LAYERS   = 12,
    parameter int COLOR_W      = COLOR_W_DEF,
    parameter int FLASH_LAYER  = 0,
    parameter int FLASH_FRAMES = 30
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [9:0]                         VGA_row,
    input  logic [9:0]                         VGA_col,
    input  logic [NUM_LAYERS-1:0][COLOR_W-1:0] layer_color,
    input  logic [NUM_LAYERS-1:0]              layer_active,
    input  logic [NUM_LAYERS-1:0]              layer_enable_req,
    input  logic [COLOR_W-1:0]                 bg_color,
    input  logic [COLOR_W-1:0]                 flash_color,
    input  logic                               flash_trigger,
    input  logic                               testpattern_active,
    output logic [COLOR_W-1:0]                 output_color,
    output logic [9:0]                         out_row,
    output logic [9:0]                         out_col,
    output logic                               frame_start,
    output logic                               flash_busy
);

    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int CH_W  = COLOR_W / 3;

    logic [NUM_LAYERS-1:0] r_enable_mask;
    logic                  r_frame_start;
    flash_state_t          r_flash_state;
    logic [7:0]            r_flash_cnt;

    logic                  r_s1_valid;
    logic [9:0]            r_s1_row;
    logic [9:0]            r_s1_col;
    logic                  r_s1_hit;
    logic                  r_s1_is_flash_layer;
    logic [COLOR_W-1:0]    r_s1_color;

    logic [COLOR_W-1:0]    r_out_color;
    logic [9:0]            r_out_row;
    logic [9:0]            r_out_col;

    logic                  w_at_origin;
    logic [NUM_LAYERS-1:0] w_mask_now;
    logic [NUM_LAYERS-1:0] w_candidates;
    logic [IDX_W-1:0]      w_win_idx;
    logic                  w_hit;
    logic [COLOR_W-1:0]    w_win_color;
    logic [2:0]            w_tp_rgb;
    logic [COLOR_W-1:0]    w_tp_color;
    logic [COLOR_W-1:0]    w_s2_color;

    // The newly requested mask already governs pixel (0,0) itself.
    assign w_at_origin  = (VGA_row == 10'd0) && (VGA_col == 10'd0);
    assign w_mask_now   = w_at_origin ? layer_enable_req : r_enable_mask;
    assign w_candidates = layer_active & w_mask_now;

    priority_select #(.NUM_LAYERS(NUM_LAYERS)) u_priority_select (
        .i_req (w_candidates),
        .o_idx (w_win_idx),
        .o_hit (w_hit)
    );

    assign w_win_color = layer_color[w_win_idx];

    // Latch the enable mask only at frame start to avoid tearing mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable_mask <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_at_origin;
            if (w_at_origin)
                r_enable_mask <= layer_enable_req;
        end
    end

    // Flash timer: trigger always (re)loads; frame boundaries count down.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flash_state <= IDLE;
            r_flash_cnt   <= 8'd0;
        end else if (flash_trigger) begin
            r_flash_state <= FLASH;
            r_flash_cnt   <= 8'(FLASH_FRAMES);
        end else if ((r_flash_state == FLASH) && w_at_origin) begin
            if (r_flash_cnt <= 8'd1) begin
                r_flash_cnt   <= 8'd0;
                r_flash_state <= IDLE;
            end else begin
                r_flash_cnt <= r_flash_cnt - 8'd1;
            end
        end
    end

    // Stage 1: register coordinates and the resolved winner of this pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid          <= 1'b0;
            r_s1_row            <= 10'd0;
            r_s1_col            <= 10'd0;
            r_s1_hit            <= 1'b0;
            r_s1_is_flash_layer <= 1'b0;
            r_s1_color          <= '0;
        end else begin
            r_s1_valid          <= 1'b1;
            r_s1_row            <= VGA_row;
            r_s1_col            <= VGA_col;
            r_s1_hit            <= w_hit;
            r_s1_is_flash_layer <= (w_win_idx == IDX_W'(FLASH_LAYER));
            r_s1_color          <= w_win_color;
        end
    end

    assign w_tp_rgb   = tp_rgb(r_s1_row, r_s1_col);
    assign w_tp_color = {{CH_W{w_tp_rgb[2]}}, {CH_W{w_tp_rgb[1]}}, {CH_W{w_tp_rgb[0]}}};

    // Stage-2 color select; a flushed stage 1 yields black.
    always_comb begin
        w_s2_color = '0;
        if (!r_s1_valid)
            w_s2_color = '0;
        else if (testpattern_active)
            w_s2_color = w_tp_color;
        else if (r_s1_hit)
            w_s2_color = (r_s1_is_flash_layer && (r_flash_state == FLASH)) ? flash_color : r_s1_color;
        else
            w_s2_color = bg_color;
    end

    // Stage 2: output registers aligned with the delayed coordinates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_color <= '0;
            r_out_row   <= 10'd0;
            r_out_col   <= 10'd0;
        end else begin
            r_out_color <= w_s2_color;
            r_out_row   <= r_s1_row;
            r_out_col   <= r_s1_col;
        end
    end

    assign output_color = r_out_color;
    assign out_row      = r_out_row;
    assign out_col      = r_out_col;
    assign frame_start  = r_frame_start;
    assign flash_busy   = (r_flash_state == FLASH);

endmodule

// File: doc/graphics_compositor.md
# graphics_compositor

Parametrised, pipelined pixel compositor that replaces the fixed-priority combinational color mux in the graphics top level. It takes NUM_LAYERS pixel-driver outputs (color + active) and picks the highest-index active, enabled layer per pixel, falling back to a background color. It adds frame-synchronous layer-enable switching, a multi-frame border-flash timer and a registered test-pattern generator. It sits between the per-region pixel drivers and the VGA output stage.

## Interface
- NUM_LAYERS, 12, number of pixel-driver inputs; index NUM_LAYERS-1 has highest priority
- COLOR_W, 24, color width (R[23:16], G[15:8], B[7:0] at default)
- FLASH_LAYER, 0, layer index whose color is replaced by flash_color while a flash runs
- FLASH_FRAMES, 30, flash length in frames (1..255)
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- VGA_row  in  10  current pixel row
- VGA_col  in  10  current pixel column
- layer_color  in  [NUM_LAYERS][COLOR_W]  per-layer pixel color
- layer_active  in  NUM_LAYERS  per-layer "pixel is mine" flag
- layer_enable_req  in  NUM_LAYERS  requested enable mask (screen dependent)
- bg_color  in  COLOR_W  color when no layer wins
- flash_color  in  COLOR_W  substitute color for FLASH_LAYER during a flash
- flash_trigger  in  1  one-cycle pulse starting/restarting a flash
- testpattern_active  in  1  selects test pattern instead of composited image
- output_color  out  COLOR_W  composited pixel, 2 cycles behind VGA_row/VGA_col
- out_row  out  10  VGA_row delayed 2 cycles (matches output_color)
- out_col  out  10  VGA_col delayed 2 cycles
- frame_start  out  1  one-cycle pulse, registered, when (VGA_row,VGA_col)==(0,0) is sampled
- flash_busy  out  1  high while flash state is FLASH

## Operation
- Enable mask: internal enable_mask loads layer_enable_req only on the cycle (0,0) is sampled; mid-frame changes to layer_enable_req are ignored until next frame. Prevents tearing on screen change.
- Stage 1 (register): capture row, col, layer_color, layer_active & enable_mask; compute winner = highest index i with active&enabled, plus hit flag.
- Stage 2 (register): if testpattern_active (stage-2 sampled), output test pattern from delayed coords; else if hit, color[winner] (flash_color if winner==FLASH_LAYER and FLASH); else bg_color.
- Test pattern: row<240: 80-col bars, col 0-79 white, 80-159 yellow, 160-239 cyan, 240-319 green, 320-399 magenta, 400-479 red, 480-559 blue, ≥560 black; row≥240 black. Channel = all-ones (255) or 0.
- Flash FSM, states IDLE, FLASH; 8-bit counter.
  - flash_trigger in any state: counter <= FLASH_FRAMES, state <= FLASH.
  - FLASH, frame boundary, no trigger: counter--; counter reaching 0 → IDLE.
  - trigger and frame boundary same cycle: trigger wins (load, no decrement).
- Flash substitution applies only to FLASH_LAYER; other layers unchanged.

## Timing
- Latency exactly 2 cycles for output_color, out_row, out_col; throughput 1 pixel/cycle, no stalls.
- frame_start asserts 1 cycle after (0,0) is presented; enable_mask takes effect for pixel (0,0) itself.
- flash_busy rises the cycle after flash_trigger; flash visible from the next pixel entering stage 2.
- Reset values: output_color=0, out_row=0, out_col=0, frame_start=0, flash_busy=0, enable_mask=0 (all layers off → bg_color until first frame start), counter=0, state IDLE. Reset mid-frame: pipeline flushed, output black for 2 cycles then bg_color until next (0,0).
- Ties impossible: priority is strict by index.

## Structure
- DisplayPkg: COLOR_W default, test-pattern bar width (80) and split row (240), flash_state_t enum {IDLE, FLASH}.
- Sub-module priority_select (NUM_LAYERS): combinational highest-set-bit encoder returning index and hit; used in stage 1.

## Test plan
- Reset then scan frame with layer_enable_req=all ones, layers 2 and 7 active at (100,50) -> output at +2 cycles = layer_color[7]; none active -> bg_color.
- Change layer_enable_req to 0 at row 100 -> output unchanged for rest of frame; after next (0,0), output = bg_color everywhere.
- flash_trigger with FLASH_FRAMES=3, FLASH_LAYER winning -> flash_color for 3 frame boundaries, flash_busy drops on third (0,0).
- flash_trigger coincident with frame_start cycle during FLASH (counter=1) -> counter reloads to FLASH_FRAMES, flash_busy stays high.
- testpattern_active=1: (10,100) -> 0xFFFF00, (10,500) -> 0x0000FF, (300,0) -> 0x000000.
- Assert rst mid-frame -> output_color=0 next cycle, outputs bg_color after 2 cycles until next (0,0) loads the mask.
